// File: rtl/det_frame_sched_pkg.sv
// Shared definitions for the time-shared sequence-detector scheduler:
// FSM state encoding and default sizing.
package det_frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NREQ_DEF    = 4;
  localparam int FRAME_W_DEF = 8;
  localparam int CNT_W_DEF   = 4;

endpackage

// File: rtl/det_frame_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps,
// and the result is one-hot (or zero when nothing is requested).
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  logic [2*NREQ-1:0] req_dbl;
  logic [2*NREQ-1:0] gnt_dbl;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   first;

  // Rotate so ptr lands on bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req};
    rot     = NREQ'(req_dbl >> ptr);
    first   = rot & (~rot + NREQ'(1));
    gnt_dbl = {first, first} << ptr;
    gnt     = gnt_dbl[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/det_frame_sched.sv
// Time-shares one serial Mealy detector among NREQ requesters: arbitrate,
// clear the detector, shift the frame MSB-first, count detector hits.
module det_frame_sched
  import det_frame_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*FRAME_W-1:0] frame,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [CNT_W-1:0]        match_cnt,
  output logic                    hit,
  output logic                    busy,
  output logic                    det_reset,
  output logic                    det_inp,
  input  logic                    det_outp
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0]    arb_gnt;
  logic [FRAME_W-1:0] sel_frame;
  logic [IDX_W-1:0]   served_idx;
  logic [IDX_W-1:0]   ptr_next;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    sel_frame  = '0;
    served_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_frame = sel_frame | (frame[i*FRAME_W +: FRAME_W] & {FRAME_W{arb_gnt[i]}});
      if (grant_q[i]) served_idx = IDX_W'(i);
    end
    ptr_next = (served_idx == IDX_W'(NREQ - 1)) ? '0 : served_idx + IDX_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = arb_gnt;
          shreg_d = sel_frame;
          cnt_d   = '0;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        bit_idx_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (det_outp) cnt_d = cnt_q + CNT_W'(1);
        shreg_d   = shreg_q << 1;
        bit_idx_d = bit_idx_q + BIT_W'(1);
        if (bit_idx_q == BIT_W'(FRAME_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        grant_d = '0;
        ptr_d   = ptr_next;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  // All handshake outputs decode from state so an async reset clears them at once.
  assign grant     = grant_q;
  assign done      = (state_q == ST_DONE) ? grant_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign det_reset = reset | (state_q == ST_CLR);
  assign det_inp   = (state_q == ST_SHIFT) ? shreg_q[FRAME_W-1] : 1'b0;
  assign match_cnt = cnt_q;
  assign hit       = (cnt_q != '0);

endmodule

// File: tb/tb_det_frame_sched.sv
// Self-checking bench for det_frame_sched: table-driven single frames,
// hand-written arbitration/reset sequences, and randomized traffic vs a model.
module tb_det_frame_sched;

  localparam int NREQ = 4;
  localparam int FW   = 8;
  localparam int CW   = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*FW-1:0] frame;
  logic [NREQ-1:0]   grant, done;
  logic [CW-1:0]     match_cnt;
  logic              hit, busy, det_reset, det_inp, det_outp;

  logic              use_mealy;
  logic [1:0]        det_st;

  int tests = 0;
  int fails = 0;

  det_frame_sched #(.NREQ(NREQ), .FRAME_W(FW), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .frame     (frame),
    .grant     (grant),
    .done      (done),
    .match_cnt (match_cnt),
    .hit       (hit),
    .busy      (busy),
    .det_reset (det_reset),
    .det_inp   (det_inp),
    .det_outp  (det_outp)
  );

  always #5 clock = ~clock;

  // Detector: either a pass-through stub, or a Mealy "101" detector with overlap.
  assign det_outp = use_mealy ? ((det_st == 2'd2) && det_inp) : det_inp;
  always @(posedge clock) begin
    if (det_reset) det_st <= 2'd0;
    else begin
      case (det_st)
        2'd0:    det_st <= det_inp ? 2'd1 : 2'd0;
        2'd1:    det_st <= det_inp ? 2'd1 : 2'd2;
        2'd2:    det_st <= det_inp ? 2'd1 : 2'd0;
        default: det_st <= 2'd0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected count: ones in the frame (stub) or "101" occurrences MSB-first (Mealy).
  function automatic int ref_count(input logic [FW-1:0] f, input bit mealy);
    int n = 0;
    if (!mealy) begin
      for (int k = 0; k < FW; k++) n += int'(f[k]);
    end else begin
      for (int k = 0; k <= FW - 3; k++)
        if (f[FW-1-k] && !f[FW-2-k] && f[FW-3-k]) n++;
    end
    return n;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] r);
    for (int off = 0; off < NREQ; off++) begin
      int idx;
      idx = (ptr + off) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  typedef struct {
    int          idx;
    logic [FW-1:0] f;
    bit          mealy;
    int          exp_cnt;
    bit          exp_hit;
  } vec_t;

  vec_t vecs[6];

  task automatic run_single(input int n, input vec_t v);
    @(negedge clock);
    use_mealy = v.mealy;
    frame[v.idx*FW +: FW] = v.f;
    req = NREQ'(32'(1) << v.idx);
    @(negedge clock);
    check($sformatf("v%0d grant", n), grant, 32'(1) << v.idx);
    check($sformatf("v%0d det_reset CLR", n), det_reset, 1);
    check($sformatf("v%0d busy", n), busy, 1);
    req = '0;
    for (int k = 0; k < FW; k++) begin
      @(negedge clock);
      check($sformatf("v%0d det_inp[%0d]", n, k), det_inp, v.f[FW-1-k]);
      check($sformatf("v%0d det_reset shift[%0d]", n, k), det_reset, 0);
    end
    @(negedge clock);
    check($sformatf("v%0d done", n), done, 32'(1) << v.idx);
    check($sformatf("v%0d match_cnt", n), match_cnt, v.exp_cnt);
    check($sformatf("v%0d hit", n), hit, v.exp_hit);
    @(negedge clock);
    check($sformatf("v%0d done low", n), done, 0);
    check($sformatf("v%0d idle busy", n), busy, 0);
    check($sformatf("v%0d cnt held", n), match_cnt, v.exp_cnt);
    $display("[TB] vector %0d req%0d frame=%b count=%0d", n, v.idx, v.f, match_cnt);
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy && c < 40) begin
      @(negedge clock);
      c++;
    end
    check({name, " idle timeout"}, busy, 0);
  endtask

  initial begin
    logic [NREQ-1:0] exp_g[5];
    int gcyc[5];
    int ng, cyc, t;
    logic [NREQ-1:0] prev_g;

    reset = 1'b1; req = '0; frame = '0; use_mealy = 1'b0;
    @(negedge clock); @(negedge clock);
    check("rst grant", grant, 0);
    check("rst done", done, 0);
    check("rst busy", busy, 0);
    check("rst match_cnt", match_cnt, 0);
    check("rst hit", hit, 0);
    check("rst det_inp", det_inp, 0);
    check("rst det_reset", det_reset, 1);
    reset = 1'b0;
    @(negedge clock);
    check("post-rst det_reset", det_reset, 0);

    // ---- table-driven single transactions (last one serves req1: pointer -> 2)
    vecs[0] = '{idx: 0, f: 8'hB2,        mealy: 1'b0, exp_cnt: 4, exp_hit: 1'b1};
    vecs[1] = '{idx: 0, f: 8'h00,        mealy: 1'b0, exp_cnt: 0, exp_hit: 1'b0};
    vecs[2] = '{idx: 0, f: 8'hFF,        mealy: 1'b0, exp_cnt: 8, exp_hit: 1'b1};
    vecs[3] = '{idx: 2, f: 8'b1010_1101, mealy: 1'b1, exp_cnt: 3, exp_hit: 1'b1};
    vecs[4] = '{idx: 3, f: 8'b1010_1000, mealy: 1'b1, exp_cnt: 2, exp_hit: 1'b1};
    vecs[5] = '{idx: 1, f: 8'b0100_1000, mealy: 1'b1, exp_cnt: 0, exp_hit: 1'b0};
    for (int n = 0; n < 6; n++) run_single(n, vecs[n]);

    // ---- req=1111 held from reset release: rotation restarts at requester 0
    use_mealy = 1'b0;
    reset = 1'b1; req = 4'hF; frame = 32'h5A3C_96E1;
    @(negedge clock);
    check("mid-rst det_reset", det_reset, 1);
    reset = 1'b0;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    ng = 0; cyc = 0; prev_g = '0;
    while (ng < 5 && cyc < 80) begin
      @(negedge clock);
      cyc++;
      if (grant != '0 && prev_g == '0) begin
        gcyc[ng] = cyc;
        check($sformatf("rr grant %0d", ng), grant, exp_g[ng]);
        if (ng == 0) check("rr first grant cycle", cyc, 1);
        else check($sformatf("rr spacing %0d", ng), gcyc[ng] - gcyc[ng-1], 11);
        $display("[TB] rr grant %0d = %b at cycle %0d", ng, grant, cyc);
        ng++;
      end
      prev_g = grant;
    end
    check("rr grant count", ng, 5);
    req = '0;
    wait_idle("rr");
    @(negedge clock);

    // ---- req0 in service, req2 raised mid-SHIFT (pointer now 1, req1 low)
    frame[0 +: FW] = 8'h3C; frame[2*FW +: FW] = 8'hC3;
    req = 4'b0001;
    t = 0;
    do begin @(negedge clock); t++; end while (grant != 4'b0001 && t < 20);
    check("seq2 grant0", grant, 4'b0001);
    req = '0;
    repeat (3) @(negedge clock);
    req[2] = 1'b1;
    t = 0;
    do begin @(negedge clock); t++; end while (done != 4'b0001 && t < 20);
    check("seq2 done0", done, 4'b0001);
    check("seq2 cnt0", match_cnt, ref_count(8'h3C, 1'b0));
    @(negedge clock);
    check("seq2 gap grant", grant, 0);
    check("seq2 gap busy", busy, 0);
    @(negedge clock);
    check("seq2 grant2", grant, 4'b0100);
    req = '0;
    t = 2;
    while (done == '0 && t < 30) begin @(negedge clock); t++; end
    check("seq2 done2", done, 4'b0100);
    check("seq2 done spacing", t, 11);
    check("seq2 cnt2", match_cnt, ref_count(8'hC3, 1'b0));
    $display("[TB] seq2 done2 %0d cycles after done0, count=%0d", t, match_cnt);
    @(negedge clock);

    // ---- async reset mid-SHIFT (pointer now 3 before the abort)
    req = 4'b0001;
    t = 0;
    do begin @(negedge clock); t++; end while (grant != 4'b0001 && t < 20);
    check("seq3 grant0", grant, 4'b0001);
    req = '0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("seq3 abort grant", grant, 0);
    check("seq3 abort done", done, 0);
    check("seq3 abort busy", busy, 0);
    check("seq3 abort det_inp", det_inp, 0);
    check("seq3 abort det_reset", det_reset, 1);
    req = 4'b1010;
    repeat (3) begin
      @(negedge clock);
      check("seq3 no done in reset", done, 0);
    end
    reset = 1'b0;
    @(negedge clock);
    check("seq3 regrant from 0", grant, 4'b0010);
    t = 0;
    do begin @(negedge clock); t++; end while (done == '0 && t < 20);
    check("seq3 done1", done, 4'b0010);
    req = 4'b1000;
    @(negedge clock);
    @(negedge clock);
    check("seq3 grant3", grant, 4'b1000);
    req = '0;
    wait_idle("seq3");
    $display("[TB] seq3 reset abort and re-arbitration done");

    // ---- randomized traffic vs round-robin / count model
    for (int phase = 0; phase < 2; phase++) begin
      logic [NREQ-1:0] pend, req_prev, prev_grant;
      logic [FW-1:0]   fr[NREQ];
      int model_ptr, issued, served, cur_idx, gc, rc, ntx;
      bit in_txn;
      ntx = 30;
      reset = 1'b1; req = '0;
      use_mealy = (phase == 1);
      @(negedge clock);
      reset = 1'b0;
      model_ptr = 0; issued = 0; served = 0; cur_idx = 0; gc = 0; rc = 0;
      in_txn = 0; pend = '0; req_prev = '0; prev_grant = '0;
      for (int i = 0; i < NREQ; i++) fr[i] = '0;
      while (served < ntx && rc < 800) begin
        @(negedge clock);
        rc++;
        if (grant != '0 && prev_grant == '0) begin
          cur_idx = rr_pick(model_ptr, req_prev);
          check("rand grant", grant, (cur_idx < 0) ? 0 : (32'(1) << cur_idx));
          gc = rc;
          in_txn = 1;
        end
        if (done != '0) begin
          if (in_txn) begin
            check("rand done", done, 32'(1) << cur_idx);
            check("rand latency", rc - gc, FW + 1);
            check("rand match_cnt", match_cnt, ref_count(fr[cur_idx], use_mealy));
            check("rand hit", hit, ref_count(fr[cur_idx], use_mealy) != 0);
            $display("[TB] rand ph%0d req%0d frame=%b count=%0d", phase, cur_idx, fr[cur_idx], match_cnt);
            model_ptr = (cur_idx + 1) % NREQ;
            pend[cur_idx] = 1'b0;
            served++;
            in_txn = 0;
          end else begin
            check("rand stray done", done, 0);
          end
        end
        for (int i = 0; i < NREQ; i++) begin
          if (!pend[i] && issued < ntx && $urandom_range(0, 3) == 0) begin
            fr[i] = FW'($urandom);
            pend[i] = 1'b1;
            issued++;
          end
          frame[i*FW +: FW] = fr[i];
        end
        req = pend;
        req_prev = req;
        prev_grant = grant;
      end
      check("rand all served", served, ntx);
      req = '0;
      wait_idle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
